// File: rtl/fx68k_bus_pkg.sv
// rtl/fx68k_bus_pkg.sv - state encoding, region decode and constants for fx68k_bus_ctrl
package fx68k_bus_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RAM   = 3'd1;
  localparam logic [2:0] S_IO    = 3'd2;
  localparam logic [2:0] S_UNMAP = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  typedef enum logic [1:0] {
    REG_RAM   = 2'd0,
    REG_IO    = 2'd1,
    REG_UNMAP = 2'd2
  } region_t;

  localparam logic [15:0] UNMAP_READ = 16'hFFFF;

endpackage

// File: rtl/fx68k_bus_decode.sv
// rtl/fx68k_bus_decode.sv - combinational CPU address to region / RAM / IO address decode
module fx68k_bus_decode
  import fx68k_bus_pkg::*;
#(
  parameter int          RAM_AW  = 12,
  parameter logic [7:0]  IO_PAGE = 8'hFF
) (
  input  logic [23:1]       i_a,
  output region_t           o_region,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [7:0]        o_io_addr
);

  // The IO page wins over RAM so a small IO_PAGE can never alias RAM.
  always_comb begin
    o_region = REG_UNMAP;
    if (i_a[23:16] == IO_PAGE) begin
      o_region = REG_IO;
    end else if (i_a[23:RAM_AW+1] == '0) begin
      o_region = REG_RAM;
    end
  end

  assign o_ram_addr = i_a[RAM_AW:1];
  assign o_io_addr  = i_a[8:1];

endmodule

// File: rtl/fx68k_bus_ctrl.sv
// rtl/fx68k_bus_ctrl.sv - fx68k bus sequencer: RAM/IO/unmapped decode with DTACK/BERR handshake
// Optional watchdog and bus-error path enabled by defining BUS_WATCHDOG_EN.
module fx68k_bus_ctrl
  import fx68k_bus_pkg::*;
#(
  parameter int          RAM_AW   = 12,
  parameter int          RAM_WAIT = 1,
  parameter logic [7:0]  IO_PAGE  = 8'hFF,
  parameter int          TIMEOUT  = 64
) (
  input  logic              clk25_mhz,
  input  logic              pwr_up_reset_n,
  input  logic              cpu_as_n,
  input  logic              cpu_rw,
  input  logic              cpu_uds_n,
  input  logic              cpu_lds_n,
  input  logic [23:1]       cpu_a,
  input  logic [15:0]       cpu_dout,
  output logic [15:0]       cpu_din,
  output logic              cpu_dtack_n,
  output logic              cpu_berr_n,
  output logic              ram_cs,
  output logic [1:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [1:0]        io_be,
  output logic [7:0]        io_addr,
  output logic [15:0]       io_wdata,
  input  logic [15:0]       io_rdata,
  input  logic              io_ack
);

  localparam int CNT_MAX = (RAM_WAIT > TIMEOUT) ? RAM_WAIT : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rw;
  logic [15:0]       r_din;
  logic              r_dtack_n;
  logic              r_ram_cs;
  logic [1:0]        r_ram_we;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [15:0]       r_wdata;
  logic              r_io_req;
  logic              r_io_we;
  logic [1:0]        r_io_be;
  logic [7:0]        r_io_addr;

  region_t           w_region;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [7:0]        w_io_addr;
  logic [1:0]        w_lanes;
  logic              w_start;

  fx68k_bus_decode #(
    .RAM_AW  (RAM_AW),
    .IO_PAGE (IO_PAGE)
  ) u_decode (
    .i_a        (cpu_a),
    .o_region   (w_region),
    .o_ram_addr (w_ram_addr),
    .o_io_addr  (w_io_addr)
  );

  assign w_lanes = {~cpu_uds_n, ~cpu_lds_n};
  // Writes raise UDS/LDS after AS, so a cycle only starts once a data strobe is seen.
  assign w_start = ~cpu_as_n & (w_lanes != 2'b00);

`ifdef BUS_WATCHDOG_EN
  logic r_berr_n;
  assign cpu_berr_n = r_berr_n;
`else
  assign cpu_berr_n = 1'b1;
`endif

  always_ff @(posedge clk25_mhz or negedge pwr_up_reset_n) begin
    if (!pwr_up_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rw       <= 1'b1;
      r_din      <= 16'h0000;
      r_dtack_n  <= 1'b1;
      r_ram_cs   <= 1'b0;
      r_ram_we   <= 2'b00;
      r_ram_addr <= '0;
      r_wdata    <= 16'h0000;
      r_io_req   <= 1'b0;
      r_io_we    <= 1'b0;
      r_io_be    <= 2'b00;
      r_io_addr  <= 8'h00;
`ifdef BUS_WATCHDOG_EN
      r_berr_n   <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rw       <= cpu_rw;
            r_wdata    <= cpu_dout;
            r_ram_addr <= w_ram_addr;
            r_io_addr  <= w_io_addr;
            r_cnt      <= '0;
            case (w_region)
              REG_RAM: begin
                r_ram_cs <= 1'b1;
                r_ram_we <= cpu_rw ? 2'b00 : w_lanes;
                r_state  <= S_RAM;
              end
              REG_IO: begin
                r_io_req <= 1'b1;
                r_io_we  <= ~cpu_rw;
                r_io_be  <= w_lanes;
                r_state  <= S_IO;
              end
              default: r_state <= S_UNMAP;
            endcase
          end
        end

        S_RAM: begin
          r_ram_cs <= 1'b0;
          r_ram_we <= 2'b00;
          if (cpu_as_n) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_W'(RAM_WAIT)) begin
            if (r_rw) r_din <= ram_rdata;
            r_dtack_n <= 1'b0;
            r_state   <= S_ACK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_IO: begin
          // An abort takes priority over an ack arriving in the same cycle.
          if (cpu_as_n) begin
            r_io_req <= 1'b0;
            r_io_we  <= 1'b0;
            r_io_be  <= 2'b00;
            r_state  <= S_IDLE;
          end else if (io_ack) begin
            r_io_req <= 1'b0;
            r_io_we  <= 1'b0;
            r_io_be  <= 2'b00;
            if (r_rw) r_din <= io_rdata;
            r_dtack_n <= 1'b0;
            r_state   <= S_ACK;
          end
`ifdef BUS_WATCHDOG_EN
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_io_req <= 1'b0;
            r_io_we  <= 1'b0;
            r_io_be  <= 2'b00;
            r_berr_n <= 1'b0;
            r_state  <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end

        S_UNMAP: begin
`ifdef BUS_WATCHDOG_EN
          r_berr_n <= 1'b0;
          r_state  <= S_ERR;
`else
          if (r_rw) r_din <= UNMAP_READ;
          r_dtack_n <= 1'b0;
          r_state   <= S_ACK;
`endif
        end

        S_ACK: begin
          if (cpu_as_n) begin
            r_dtack_n <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

`ifdef BUS_WATCHDOG_EN
        S_ERR: begin
          if (cpu_as_n) begin
            r_berr_n <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_din     = r_din;
  assign cpu_dtack_n = r_dtack_n;
  assign ram_cs      = r_ram_cs;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_wdata;
  assign io_req      = r_io_req;
  assign io_we       = r_io_we;
  assign io_be       = r_io_be;
  assign io_addr     = r_io_addr;
  assign io_wdata    = r_wdata;

endmodule

// File: tb/tb_fx68k_bus_ctrl.sv
// tb/tb_fx68k_bus_ctrl.sv - directed self-checking bench for fx68k_bus_ctrl
module tb_fx68k_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        as_n, rw, uds_n, lds_n;
  logic [23:1] a;
  logic [15:0] dout;
  logic [15:0] din;
  logic        dtack, berr;
  logic        ram_cs;
  logic [1:0]  ram_we;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        io_req, io_we;
  logic [1:0]  io_be;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        io_ack;

  logic [15:0] mem [0:4095];
  int          cs_cnt;
  int          total = 0;
  int          bad   = 0;
  int          n;
  int          cs_before;

  always #5 clk = ~clk;

  fx68k_bus_ctrl #(.RAM_AW(12), .RAM_WAIT(1), .IO_PAGE(8'hFF), .TIMEOUT(64)) dut (
    .clk25_mhz      (clk),
    .pwr_up_reset_n (rst_n),
    .cpu_as_n       (as_n),
    .cpu_rw         (rw),
    .cpu_uds_n      (uds_n),
    .cpu_lds_n      (lds_n),
    .cpu_a          (a),
    .cpu_dout       (dout),
    .cpu_din        (din),
    .cpu_dtack_n    (dtack),
    .cpu_berr_n     (berr),
    .ram_cs         (ram_cs),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .io_req         (io_req),
    .io_we          (io_we),
    .io_be          (io_be),
    .io_addr        (io_addr),
    .io_wdata       (io_wdata),
    .io_rdata       (io_rdata),
    .io_ack         (io_ack)
  );

  // Synchronous byte-lane RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[3]  <= 16'h0008;
      mem[9]  <= 16'h5566;
      cs_cnt  <= 0;
    end else if (ram_cs) begin
      cs_cnt <= cs_cnt + 1;
      if (ram_we[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
      if (ram_we[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [23:0] ba, input logic r, input logic u_n,
                       input logic l_n, input logic [15:0] d);
    a     = ba[23:1];
    rw    = r;
    uds_n = u_n;
    lds_n = l_n;
    dout  = d;
    as_n  = 1'b0;
  endtask

  task automatic end_cycle();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    rw    = 1'b1;
  endtask

  task automatic wait_low(input bit use_berr, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((use_berr ? berr : dtack) !== 1'b0 && cnt < 200);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; as_n = 1'b1; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    a = '0; dout = 16'h0000; io_rdata = 16'h0000; io_ack = 1'b0;
    tick(); tick();
    chk("rst_dtack", dtack, 1);
    chk("rst_berr", berr, 1);
    chk("rst_din", din, 16'h0000);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_we", ram_we, 2'b00);
    chk("rst_io", {io_req, io_we, io_be}, 4'b0000);
    chk("rst_ram_addr", ram_addr, 12'h000);
    #3 rst_n = 1'b1;
    tick();

    // Word read of RAM word 3
    start(24'h000006, 1'b1, 1'b0, 1'b0, 16'h0000);
    cs_before = cs_cnt;
    tick();
    chk("rd_cs", ram_cs, 1);
    chk("rd_addr", ram_addr, 12'd3);
    chk("rd_we", ram_we, 2'b00);
    chk("rd_dtack_e0", dtack, 1);
    tick();
    chk("rd_cs_drop", ram_cs, 0);
    chk("rd_dtack_e1", dtack, 1);
    tick();
    chk("rd_dtack_e2", dtack, 0);
    chk("rd_din", din, 16'h0008);
    tick();
    chk("rd_dtack_hold", dtack, 0);
    end_cycle();
    tick();
    chk("rd_dtack_rel", dtack, 1);
    chk("rd_cs_pulses", cs_cnt - cs_before, 1);

    // Lower-byte write 0x34 to byte address 0x0013
    start(24'h000013, 1'b0, 1'b1, 1'b0, 16'h1234);
    tick();
    chk("bw_we", ram_we, 2'b01);
    chk("bw_addr", ram_addr, 12'd9);
    chk("bw_wdata", ram_wdata, 16'h1234);
    wait_low(1'b0, n);
    chk("bw_lat", n, 2);
    end_cycle();
    tick();
    chk("bw_mem", mem[9], 16'h5534);

    // Upper-byte readback keeps the old byte
    start(24'h000012, 1'b1, 1'b0, 1'b1, 16'h0000);
    tick();
    chk("ub_we", ram_we, 2'b00);
    wait_low(1'b0, n);
    chk("ub_lat", n, 2);
    chk("ub_din_hi", din[15:8], 8'h55);
    end_cycle();
    tick();

    // IO read at 0xFF0010 with ack five cycles after entry
    start(24'hFF0010, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("io_req_on", io_req, 1);
    chk("io_addr", io_addr, 8'h08);
    chk("io_we_be", {io_we, io_be}, 3'b011);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("io_wait", {io_req, dtack}, 2'b11);
    end
    io_ack = 1'b1; io_rdata = 16'hBEEF;
    tick();
    io_ack = 1'b0; io_rdata = 16'h0000;
    chk("io_req_off", io_req, 0);
    chk("io_dtack", dtack, 0);
    chk("io_din", din, 16'hBEEF);
    end_cycle();
    tick();
    chk("io_dtack_rel", dtack, 1);

    // IO write aborted by AS rising together with io_ack
    start(24'hFF0022, 1'b0, 1'b0, 1'b1, 16'hCAFE);
    tick();
    chk("iow_fields", {io_req, io_we, io_be, io_addr}, {1'b1, 1'b1, 2'b10, 8'h11});
    chk("iow_wdata", io_wdata, 16'hCAFE);
    end_cycle();
    io_ack = 1'b1; io_rdata = 16'h1111;
    tick();
    io_ack = 1'b0;
    chk("abort_req", io_req, 0);
    chk("abort_dtack", dtack, 1);
    tick();
    chk("abort_idle_dtack", dtack, 1);
    chk("abort_din", din, 16'hBEEF);

`ifndef BUS_WATCHDOG_EN
    // Unmapped write is discarded, unmapped read returns all ones
    cs_before = cs_cnt;
    start(24'h400000, 1'b0, 1'b0, 1'b0, 16'h7777);
    tick();
    wait_low(1'b0, n);
    chk("um_wr_lat", n, 1);
    chk("um_wr_din", din, 16'hBEEF);
    end_cycle();
    tick();
    start(24'h002000, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    wait_low(1'b0, n);
    chk("um_rd_lat", n, 1);
    chk("um_rd_din", din, 16'hFFFF);
    chk("um_berr", berr, 1);
    chk("um_no_ram", cs_cnt - cs_before, 0);
    end_cycle();
    tick();
    chk("um_dtack_rel", dtack, 1);
`else
    // Unmapped read raises BERR without DTACK
    start(24'h400000, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    wait_low(1'b1, n);
    chk("wd_um_lat", n, 1);
    chk("wd_um_dtack", dtack, 1);
    end_cycle();
    tick();
    chk("wd_um_rel", berr, 1);

    // IO with no ack times out after TIMEOUT cycles
    start(24'hFF0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    wait_low(1'b1, n);
    chk("wd_io_lat", n, 64);
    chk("wd_io_dtack", dtack, 1);
    chk("wd_io_req", io_req, 0);
    tick();
    chk("wd_io_hold", berr, 0);
    end_cycle();
    tick();
    chk("wd_io_rel", berr, 1);
    start(24'h000006, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    wait_low(1'b0, n);
    chk("wd_ram_lat", n, 2);
    chk("wd_ram_din", din, 16'h0008);
    end_cycle();
    tick();
`endif

    // RAM boundary: last word is RAM, first byte past it is not
    start(24'h001FFE, 1'b0, 1'b0, 1'b0, 16'hA5A5);
    tick();
    chk("top_addr", ram_addr, 12'hFFF);
    chk("top_we", ram_we, 2'b11);
    wait_low(1'b0, n);
    chk("top_lat", n, 2);
    end_cycle();
    tick();
    chk("top_mem", mem[4095], 16'hA5A5);

    // Reset pulse during the RAM wait state
    start(24'h000012, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("mr_cs", ram_cs, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_cs_rst", ram_cs, 0);
    chk("mr_din_rst", din, 16'h0000);
    chk("mr_dtack_rst", dtack, 1);
    chk("mr_addr_rst", ram_addr, 12'h000);
    end_cycle();
    tick();
    #2 rst_n = 1'b1;
    tick();
    start(24'h000006, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    wait_low(1'b0, n);
    chk("mr_after_lat", n, 2);
    chk("mr_after_din", din, 16'h0008);
    end_cycle();
    tick();
    chk("mr_after_rel", dtack, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
